// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths, constants and types for the 5-stage pipeline
//               stage blocks (register numbers, data words).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  // Architectural zero register number.
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_AW-1:0] regnum_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pipe_regfile
// Description : 2-read / 1-write general-purpose register array. r0 reads as
//               zero and is never written. Asynchronous active-low clear.
//               Optional write-through bypass on both read ports, enabled by
//               defining PIPE_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] rna,
  input  logic [REG_AW-1:0] rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb
);
  import pipe_pkg::*;

  localparam int                NUM_ENTRIES = 1 << REG_AW;
  localparam logic [REG_AW-1:0] c_REG_ZERO  = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [NUM_ENTRIES];
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_qa;
  logic [DATA_W-1:0] w_qb;

  // A write only lands on a non-zero register; r0 storage stays at reset zero.
  assign w_wr_ok = we && (waddr != c_REG_ZERO);

  // Register array: asynchronous clear of every entry, single write port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Combinational read ports with r0 forced to zero and optional write-through.
  always_comb begin
    w_qa = r_regs[rna];
    w_qb = r_regs[rnb];
    if (rna == c_REG_ZERO) w_qa = '0;
    if (rnb == c_REG_ZERO) w_qb = '0;
`ifdef PIPE_WB_BYPASS_EN
    // The value being committed this cycle is visible before the edge.
    if (w_wr_ok && (waddr == rna)) w_qa = wdata;
    if (w_wr_ok && (waddr == rnb)) w_qb = wdata;
`endif
  end

  assign qa = w_qa;
  assign qb = w_qb;

endmodule : pipe_regfile
`default_nettype wire

// File: rtl/pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pipe_wb_regfile
// Description : Write-back stage plus register file. Selects load data or ALU
//               result, commits it to the 32 x 32 register file, serves the two
//               ID-stage read ports and counts committed register writes.
//               Define PIPE_WB_BYPASS_EN for write-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [DATA_W-1:0] wmo,
  input  logic [DATA_W-1:0] walu,
  input  logic [REG_AW-1:0] wrn,
  input  logic [REG_AW-1:0] rna,
  input  logic [REG_AW-1:0] rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] wdi,
  output logic [CNT_W-1:0]  wb_count
);
  import pipe_pkg::*;

  localparam logic [REG_AW-1:0] c_REG_ZERO = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] w_wdi;
  logic              w_commit;
  logic [CNT_W-1:0]  r_wb_count;

  // Write-back data select; valid regardless of wwreg so forwarding can use it.
  assign w_wdi = wm2reg ? wmo : walu;

  // A write retires only outside reset and never to r0. Gating with resetn
  // also keeps a bypassed read at zero while reset is held.
  assign w_commit = resetn & wwreg & (wrn != c_REG_ZERO);

  // Retired-write counter, free-running wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wb_count <= '0;
    end else if (w_commit) begin
      r_wb_count <= r_wb_count + CNT_W'(1);
    end
  end

  pipe_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clock  (clock),
    .resetn (resetn),
    .we     (w_commit),
    .waddr  (wrn),
    .wdata  (w_wdi),
    .rna    (rna),
    .rnb    (rnb),
    .qa     (qa),
    .qb     (qb)
  );

  assign wdi      = w_wdi;
  assign wb_count = r_wb_count;

endmodule : pipe_wb_regfile
`default_nettype wire

// File: tb/tb_pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_wb_regfile
// Description : Directed scoreboard bench for pipe_wb_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_wb_regfile;

  logic        clock;
  logic        resetn;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [31:0] wdi;
  logic [31:0] wb_count;

  localparam int SIG_QA  = 0;
  localparam int SIG_QB  = 1;
  localparam int SIG_WDI = 2;
  localparam int SIG_CNT = 3;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event ev_sample;
  int   checks = 0;
  int   errors = 0;

  pipe_wb_regfile #(
    .DATA_W (32),
    .REG_AW (5),
    .CNT_W  (32)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wmo      (wmo),
    .walu     (walu),
    .wrn      (wrn),
    .rna      (rna),
    .rnb      (rnb),
    .qa       (qa),
    .qb       (qb),
    .wdi      (wdi),
    .wb_count (wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: on each sample strike, pop pending expectations and compare.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(ev_sample);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.sig)
          SIG_QA:  act = qa;
          SIG_QB:  act = qb;
          SIG_WDI: act = wdi;
          default: act = wb_count;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sig, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> ev_sample;
    #1;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mo,
                       input logic [31:0] alu, input logic [4:0] rn,
                       input logic [4:0] ra, input logic [4:0] rb);
    wwreg  = we;
    wm2reg = m2r;
    wmo    = mo;
    walu   = alu;
    wrn    = rn;
    rna    = ra;
    rnb    = rb;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
    #2;
    expect_val("reset_qa", SIG_QA, 32'h0);
    expect_val("reset_qb", SIG_QB, 32'h0);
    expect_val("reset_cnt", SIG_CNT, 32'h0);
    sample();
    tick();
    resetn = 1'b1;

    // ALU write-back to r7
    drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd7, 5'd0, 5'd0);
    expect_val("alu_wdi", SIG_WDI, 32'hDEADBEEF);
    sample();
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    expect_val("alu_qa", SIG_QA, 32'hDEADBEEF);
    expect_val("alu_cnt", SIG_CNT, 32'd1);
    sample();

    // Load write-back to r31
    drive(1'b1, 1'b1, 32'h000000A5, 32'hFFFFFFFF, 5'd31, 5'd0, 5'd0);
    expect_val("load_wdi", SIG_WDI, 32'h000000A5);
    sample();
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd31);
    expect_val("load_qb", SIG_QB, 32'h000000A5);
    expect_val("load_qa_r7", SIG_QA, 32'hDEADBEEF);
    expect_val("load_cnt", SIG_CNT, 32'd2);
    sample();

    // r0 protection
    drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_val("r0_qa", SIG_QA, 32'h0);
    expect_val("r0_cnt", SIG_CNT, 32'd2);
    sample();

    // wwreg=0 leaves r3 alone
    drive(1'b1, 1'b0, 32'h0, 32'h3333, 5'd3, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h99, 5'd3, 5'd3, 5'd0);
    expect_val("noen_wdi", SIG_WDI, 32'h99);
    sample();
    tick();
    expect_val("noen_qa", SIG_QA, 32'h3333);
    expect_val("noen_cnt", SIG_CNT, 32'd3);
    sample();

    // X on wrn while disabled
    wrn = 'x;
    tick();
    rna = 5'd7;
    expect_val("xwrn_qa", SIG_QA, 32'hDEADBEEF);
    expect_val("xwrn_cnt", SIG_CNT, 32'd3);
    sample();

    // Collision on r9
    drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd9, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h22, 5'd9, 5'd9, 5'd9);
`ifdef PIPE_WB_BYPASS_EN
    expect_val("coll_pre_qa", SIG_QA, 32'h22);
    expect_val("coll_pre_qb", SIG_QB, 32'h22);
`else
    expect_val("coll_pre_qa", SIG_QA, 32'h11);
    expect_val("coll_pre_qb", SIG_QB, 32'h11);
`endif
    sample();
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    expect_val("coll_post_qa", SIG_QA, 32'h22);
    expect_val("coll_post_qb", SIG_QB, 32'h22);
    expect_val("coll_cnt", SIG_CNT, 32'd5);
    sample();

    // Asynchronous reset mid-run with a pending write
    drive(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    expect_val("pre_rst_qa", SIG_QA, 32'h1234);
    expect_val("pre_rst_cnt", SIG_CNT, 32'd6);
    sample();
    drive(1'b1, 1'b0, 32'h0, 32'h5678, 5'd5, 5'd5, 5'd0);
    resetn = 1'b0;
    expect_val("rst_qa", SIG_QA, 32'h0);
    expect_val("rst_cnt", SIG_CNT, 32'h0);
    sample();
    tick();
    resetn = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
    expect_val("post_rst_qa", SIG_QA, 32'h0);
    expect_val("post_rst_qb", SIG_QB, 32'h0);
    expect_val("post_rst_cnt", SIG_CNT, 32'h0);
    sample();

    // Counter wrap
    force dut.r_wb_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wb_count;
    drive(1'b1, 1'b0, 32'h0, 32'hCAFE0001, 5'd1, 5'd1, 5'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd0);
    expect_val("wrap_cnt", SIG_CNT, 32'h0);
    expect_val("wrap_qa", SIG_QA, 32'hCAFE0001);
    sample();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_wb_regfile
`default_nettype wire

// File: doc/pipe_wb_regfile.md
Name: pipe_wb_regfile

Overview:
- Write-back (WB) stage and general-purpose register file of the 5-stage pipeline computer.
- Consumes the MEM/WB pipeline register outputs and selects the write-back data (memory load value or ALU result).
- Commits that data to a 32 x 32-bit register file.
- Serves the two combinational read ports used by the ID stage.
- Counts retired register writes for debug and performance.

Parameters:
- DATA_W, 32, register and data width.
- REG_AW, 5, register address width (2^REG_AW registers).
- CNT_W, 32, width of the write-back counter.

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- wwreg  input  1  WB stage register-write enable.
- wm2reg  input  1  1 selects wmo, 0 selects walu as write data.
- wmo  input  DATA_W  memory load data from MEM/WB.
- walu  input  DATA_W  ALU result from MEM/WB.
- wrn  input  REG_AW  destination register number.
- rna  input  REG_AW  read port A register number (ID stage).
- rnb  input  REG_AW  read port B register number (ID stage).
- qa  output  DATA_W  read port A data.
- qb  output  DATA_W  read port B data.
- wdi  output  DATA_W  selected write-back data, exported for forwarding.
- wb_count  output  CNT_W  number of committed register writes.

Behaviour:
- Reset: resetn=0 asynchronously clears all 32 registers and wb_count to 0. With all registers zero, qa=qb=0. wdi stays combinational from its inputs.
- Reset mid-operation: asserting resetn during any cycle discards the pending write; no partial commit.
- Write-data mux (combinational): wdi = wm2reg ? wmo : walu. It is valid whether or not wwreg is set.
- Commit rule: on posedge clock with resetn=1, if wwreg=1 and wrn != 0, then reg[wrn] <= wdi. Latency is 1 cycle from the MEM/WB outputs to architectural state.
- Register 0 is hardwired to zero:
  - Writes with wrn=0 are ignored.
  - Reads of r0 always return 0 (storage for r0 is optional but is never observable).
- Reads: qa = reg[rna] and qb = reg[rnb], combinational, no clock latency.
- Same-register reads on both ports are legal; qa=qb.
- Write/read collision (same cycle, wwreg=1, wrn=rna or rnb, wrn != 0): result is governed by the Optional Feature.
- Counter: wb_count increments by 1 on each committed write (wwreg=1 and wrn != 0).
  - Writes to r0 and cycles with wwreg=0 do not count.
  - Wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Unknown/X on wrn while wwreg=0 has no effect on state.

Optional Feature:
- Macro: PIPE_WB_BYPASS_EN.
- Defined: internal write-through bypass. When wwreg=1, wrn != 0 and rna==wrn, qa = wdi in the same cycle (likewise qb for rnb). ID sees the value being committed without an extra forwarding path.
- Undefined: the read ports return the pre-edge register contents. The hazard unit must forward wdi or stall for one cycle.
- In both cases the stored state after the clock edge is identical.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W, REG_AW, NUM_REGS.
  - REG_ZERO constant (5'd0).
  - typedef word_t (DATA_W bits) and regnum_t (REG_AW bits), reused by all pipeline-stage blocks.
- One sub-module, pipe_regfile:
  - 2-read/1-write array with r0 hardwire, async reset, and the optional bypass.
- The top level holds the wdi mux, the commit qualification and wb_count.

Test Plan:
- Reset: drive resetn=0 mid-run after writing r5=0x1234 -> qa(rna=5)=0 immediately (asynchronous); wb_count=0.
- ALU write-back: wwreg=1, wm2reg=0, walu=0xDEADBEEF, wrn=7, one clock -> rna=7 gives qa=0xDEADBEEF; wb_count=1; wdi=0xDEADBEEF during the cycle.
- Load write-back: wm2reg=1, wmo=0x0000_00A5, walu=0xFFFF_FFFF, wrn=31 -> qb(rnb=31)=0x000000A5.
- r0 protection: wwreg=1, wrn=0, walu=0x55 -> qa(rna=0)=0; wb_count unchanged.
- wwreg=0 with wrn=3, walu=0x99 -> r3 unchanged.
- Collision: r9=0x11 stored; same cycle wwreg=1, wrn=9, walu=0x22, rna=9:
  - with PIPE_WB_BYPASS_EN, qa=0x22 before the edge;
  - without it, qa=0x11 before the edge;
  - both builds give qa=0x22 after the edge.
- Counter wrap: preload or force wb_count=0xFFFFFFFF, one committed write -> wb_count=0.
